// File: rtl/seq_shift_add_mult.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, registered 2*WIDTH product.
// Define SEQ_MULT_SIGNED_EN for two's-complement operands (sign-extended b, subtract on MSB step).
module seq_shift_add_mult #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 op_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int PW    = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_mplier;
  logic [PW-1:0]    r_mcand;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_product;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_last;
  logic [PW-1:0]    w_b_ext;
  logic [PW-1:0]    w_acc_nxt;

`ifdef SEQ_MULT_SIGNED_EN
  assign w_b_ext = {{WIDTH{b[WIDTH-1]}}, b};
`else
  assign w_b_ext = {{WIDTH{1'b0}}, b};
`endif

  assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));
  assign product = r_product;

  // The multiplier's original MSB carries negative weight in signed mode.
  always_comb begin
    w_acc_nxt = r_acc;
    if (r_mplier[0]) begin
`ifdef SEQ_MULT_SIGNED_EN
      if (w_last) w_acc_nxt = r_acc - r_mcand;
      else        w_acc_nxt = r_acc + r_mcand;
`else
      w_acc_nxt = r_acc + r_mcand;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    busy        = 1'b0;
    op_ready    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        op_ready = 1'b1;
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: capture on acceptance, one shift-add step per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mplier  <= '0;
      r_mcand   <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_mplier <= a;
      r_mcand  <= w_b_ext;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (r_state == S_RUN) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_last) r_product <= w_acc_nxt;
    end
  end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed and random checks of seq_shift_add_mult at WIDTH=4 and WIDTH=8 against an arithmetic model.
module tb_seq_shift_add_mult;

  localparam int W  = 4;
  localparam int W8 = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          busy;
  logic          op_ready;
  logic [2*W-1:0] product;

  logic           start8 = 1'b0;
  logic [W8-1:0]  a8 = '0;
  logic [W8-1:0]  b8 = '0;
  logic           busy8;
  logic           op_ready8;
  logic [2*W8-1:0] product8;

  int n_chk  = 0;
  int n_fail = 0;
  logic [2*W-1:0]  last4 = '0;
  logic [2*W8-1:0] last8 = '0;

  seq_shift_add_mult #(.WIDTH(W)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .op_ready(op_ready), .product(product)
  );

  seq_shift_add_mult #(.WIDTH(W8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .op_ready(op_ready8), .product(product8)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference product: true integer product truncated to 2*width bits.
  function automatic logic [2*W-1:0] model4(input logic [W-1:0] x, input logic [W-1:0] y);
    int p;
`ifdef SEQ_MULT_SIGNED_EN
    p = int'($signed(x)) * int'($signed(y));
`else
    p = int'(x) * int'(y);
`endif
    return p[2*W-1:0];
  endfunction

  function automatic logic [2*W8-1:0] model8(input logic [W8-1:0] x, input logic [W8-1:0] y);
    int p;
`ifdef SEQ_MULT_SIGNED_EN
    p = int'($signed(x)) * int'($signed(y));
`else
    p = int'(x) * int'(y);
`endif
    return p[2*W8-1:0];
  endfunction

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input string tag);
    logic [2*W-1:0] exp;
    exp = model4(ta, tb_v);
    a = ta; b = tb_v; start = 1'b1;
    tick();
    start = 1'b0;
    a = ~ta; b = ~tb_v;
    check({tag, "_busy_on_accept"}, {30'd0, busy, op_ready}, 32'b10);
    for (int i = 1; i < W; i++) begin
      tick();
      check({tag, "_busy_run"}, {30'd0, busy, op_ready}, 32'b10);
      check({tag, "_held_run"}, 32'(product), 32'(last4));
    end
    tick();
    check({tag, "_pulse"}, {30'd0, busy, op_ready}, 32'b01);
    check({tag, "_product"}, 32'(product), 32'(exp));
    tick();
    check({tag, "_after"}, {30'd0, busy, op_ready}, 32'b00);
    check({tag, "_held"}, 32'(product), 32'(exp));
    last4 = exp;
  endtask

  task automatic run_op8(input logic [W8-1:0] ta, input logic [W8-1:0] tb_v, input string tag);
    logic [2*W8-1:0] exp;
    exp = model8(ta, tb_v);
    a8 = ta; b8 = tb_v; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check({tag, "_busy_on_accept"}, {30'd0, busy8, op_ready8}, 32'b10);
    repeat (W8 - 1) tick();
    check({tag, "_busy_last_run"}, {30'd0, busy8, op_ready8}, 32'b10);
    check({tag, "_held_run"}, 32'(product8), 32'(last8));
    tick();
    check({tag, "_pulse"}, {30'd0, busy8, op_ready8}, 32'b01);
    check({tag, "_product"}, 32'(product8), 32'(exp));
    tick();
    check({tag, "_after"}, {30'd0, busy8, op_ready8}, 32'b00);
    check({tag, "_held"}, 32'(product8), 32'(exp));
    last8 = exp;
  endtask

  initial begin
    // Reset, with a start request that must be ignored.
    rst = 1'b1; start = 1'b1; a = 4'd3; b = 4'd3;
    tick(); tick();
    check("reset_ctrl", {30'd0, busy, op_ready}, 32'b00);
    check("reset_product", 32'(product), 32'd0);
    check("reset_product8", 32'(product8), 32'd0);
    rst = 1'b0; start = 1'b0;
    tick();
    check("start_with_rst_ignored", {30'd0, busy, op_ready}, 32'b00);

    run_op(4'd15, 4'd15, "max15x15");
    check("max15x15_unsigned_value", 32'(product),
`ifdef SEQ_MULT_SIGNED_EN
          32'h01
`else
          32'hE1
`endif
    );

    run_op8(8'h00, 8'hFF, "w8_zero");
    run_op8(8'hA5, 8'h3C, "w8_a5x3c");

    // Back-to-back: start held high through RUN and DONE.
    a = 4'd3; b = 4'd5; start = 1'b1;
    tick();
    check("b2b_accept1", {30'd0, busy, op_ready}, 32'b10);
    a = 4'd7; b = 4'd9;
    repeat (W - 1) tick();
    check("b2b_run1", {30'd0, busy, op_ready}, 32'b10);
    tick();
    check("b2b_pulse1", {30'd0, busy, op_ready}, 32'b01);
    check("b2b_product1", 32'(product), 32'(model4(4'd3, 4'd5)));
    tick();
    check("b2b_accept2", {30'd0, busy, op_ready}, 32'b10);
    check("b2b_held1", 32'(product), 32'(model4(4'd3, 4'd5)));
    start = 1'b0;
    repeat (W - 1) tick();
    check("b2b_run2", {30'd0, busy, op_ready}, 32'b10);
    tick();
    check("b2b_pulse2", {30'd0, busy, op_ready}, 32'b01);
    check("b2b_product2", 32'(product), 32'(model4(4'd7, 4'd9)));
    tick();
    check("b2b_after", {30'd0, busy, op_ready}, 32'b00);
    last4 = model4(4'd7, 4'd9);

    // Start re-pulsed during RUN with new operands.
    a = 4'd6; b = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 4'd15; b = 4'd15; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("repulse_still_busy", {30'd0, busy, op_ready}, 32'b10);
    tick();
    check("repulse_pulse", {30'd0, busy, op_ready}, 32'b01);
    check("repulse_product", 32'(product), 32'(model4(4'd6, 4'd2)));
    tick();
    check("repulse_idle", {30'd0, busy, op_ready}, 32'b00);
    last4 = model4(4'd6, 4'd2);

    // Reset mid-RUN after two steps.
    a = 4'd9; b = 4'd9; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_ctrl", {30'd0, busy, op_ready}, 32'b00);
    check("midrst_product", 32'(product), 32'd0);
    last4 = '0; last8 = '0;
    for (int i = 0; i <= W; i++) begin
      tick();
      check("midrst_no_pulse", {30'd0, busy, op_ready}, 32'b00);
    end
    run_op(4'd2, 4'd3, "after_rst_2x3");

`ifdef SEQ_MULT_SIGNED_EN
    run_op(4'h8, 4'h7, "s_m8x7");
    check("s_m8x7_const", 32'(product), 32'hC8);
    run_op(4'h8, 4'h8, "s_m8xm8");
    check("s_m8xm8_const", 32'(product), 32'h40);
    run_op(4'hF, 4'hF, "s_m1xm1");
    check("s_m1xm1_const", 32'(product), 32'h01);
`endif

    for (int i = 0; i < 16; i++) begin
      run_op(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), "rand4");
    end
    for (int i = 0; i < 6; i++) begin
      run_op8(W8'($urandom_range(0, 255)), W8'($urandom_range(0, 255)), "rand8");
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_shift_add_mult.md
# seq_shift_add_mult

Parametrised sequential shift-add multiplier: multiplies two WIDTH-bit operands over WIDTH clock cycles, one multiplier bit per cycle, and presents a registered 2·WIDTH-bit product with a one-cycle completion pulse. It is the next-generation multiplier for the datapath, with a start/busy handshake, operand capture, a held result and optional two's-complement signed mode. It sits between the operand registers and the result bus.

## Interface
- WIDTH, 4, operand width in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when the block is idle.
- a  in  WIDTH  multiplier operand; captured on the accepting edge.
- b  in  WIDTH  multiplicand operand; captured on the accepting edge.
- busy  out  1  high while an operation is in progress (RUN state).
- op_ready  out  1  one-cycle pulse marking a new valid product.
- product  out  2·WIDTH  registered result; held until the next completion or reset.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: on start=1, capture a into the multiplier shift register and b, zero-extended to 2·WIDTH, into the multiplicand register. Clear the accumulator and the bit counter (width $clog2(WIDTH+1)). Go to RUN.
- RUN, one step per cycle:
  - If the multiplier LSB is 1, accumulator += multiplicand.
  - Shift the multiplicand left by 1 and the multiplier right by 1.
  - Counter += 1.
  - When the counter reaches WIDTH-1 on the current step: load product with the final accumulator value and go to DONE.
- DONE: op_ready=1 for this cycle only. If start=1, accept new operands exactly as in IDLE and go to RUN (back-to-back). Otherwise go to IDLE.
- start is ignored in RUN. Changes on a/b after capture have no effect.
- Accumulator arithmetic is modulo 2^(2·WIDTH). It never overflows in unsigned mode.
- product changes only on the completion edge or on reset. Partial sums are never visible.
- Reset (any state, including mid-RUN) aborts the operation. busy=0, op_ready=0, product=0, accumulator/registers/counter=0, state=IDLE. A start asserted together with rst is ignored.
- Output reset values: busy=0, op_ready=0, product=0.

## Timing
- Acceptance edge E (start=1 in IDLE or DONE): busy=1 from E.
- The WIDTH RUN steps occur on edges E+1 .. E+WIDTH.
- Completion edge E+WIDTH: product is valid, op_ready=1 and busy=0 from this edge, for one cycle.
- Edge E+WIDTH+1: op_ready=0. If start=1 at this edge, it is the next acceptance edge.
- Latency from acceptance to op_ready: WIDTH cycles.
- Maximum throughput: one product per WIDTH+1 cycles.
- busy and op_ready are never high in the same cycle.

## Configuration
- SEQ_MULT_SIGNED_EN defined: operands are two's complement.
  - b is sign-extended to 2·WIDTH on capture.
  - The step for multiplier bit WIDTH-1 subtracts the multiplicand instead of adding it.
  - product is the signed 2·WIDTH-bit result.
  - Timing is unchanged.
- SEQ_MULT_SIGNED_EN not defined: unsigned operation only, with no subtract path.

## Test plan
- WIDTH=4, unsigned, a=15, b=15, start for 1 cycle -> busy for 4 cycles, op_ready pulse 4 cycles after acceptance, product=8'hE1 (225), held afterwards.
- WIDTH=8, unsigned, a=0, b=8'hFF, then a=8'hA5, b=8'h3C -> product=16'h0000, then 16'h26AC; each op_ready pulse exactly 1 cycle.
- WIDTH=4, back-to-back: 3×5 accepted, start held high through DONE with a=7, b=9 -> product 15 then 63; second acceptance on the completion cycle; pulses 5 cycles apart.
- WIDTH=4, start re-pulsed in RUN with new operands -> ignored; result equals the first captured pair.
- Reset mid-RUN after 2 steps of 9×9 -> busy=0, product=0, no op_ready; a following 2×3 yields 6.
- SEQ_MULT_SIGNED_EN, WIDTH=4: a=-8, b=7 -> 8'hC8 (-56); a=-8, b=-8 -> 8'h40 (64); a=-1, b=-1 -> 8'h01.
